// File: rtl/imm_encode_pkg.sv
// Shared definitions for the RV32 immediate packer: format codes, per-format
// immediate masks, and the combinational encode/range-check function.
package imm_encode_pkg;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b010;
    localparam logic [2:0] IMM_B = 3'b110;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b111;

    localparam logic [31:0] MASK_I = 32'hFFF0_0000;
    localparam logic [31:0] MASK_S = 32'hFE00_0F80;
    localparam logic [31:0] MASK_B = 32'hFE00_0F80;
    localparam logic [31:0] MASK_U = 32'hFFFF_F000;
    localparam logic [31:0] MASK_J = 32'hFFFF_F000;

    typedef struct packed {
        logic        err;
        logic [31:0] inst;
    } enc_t;

    // Unrepresentable immediates leave the template untouched and raise err.
    function automatic enc_t encode_imm(input logic [2:0]  op,
                                        input logic [31:0] imm,
                                        input logic [31:0] tmpl);
        enc_t        r;
        logic [31:0] mask;
        logic [31:0] placed;
        logic        ok;
        mask   = '0;
        placed = '0;
        ok     = 1'b0;
        case (op)
            IMM_I: begin
                mask   = MASK_I;
                placed = {imm[11:0], 20'b0};
                ok     = (&imm[31:11]) | !(|imm[31:11]);
            end
            IMM_S: begin
                mask   = MASK_S;
                placed = {imm[11:5], 13'b0, imm[4:0], 7'b0};
                ok     = (&imm[31:11]) | !(|imm[31:11]);
            end
            IMM_B: begin
                mask   = MASK_B;
                placed = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
                ok     = ((&imm[31:12]) | !(|imm[31:12])) & !imm[0];
            end
            IMM_U: begin
                mask   = MASK_U;
                placed = {imm[31:12], 12'b0};
                ok     = !(|imm[11:0]);
            end
            IMM_J: begin
                mask   = MASK_J;
                placed = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
                ok     = ((&imm[31:20]) | !(|imm[31:20])) & !imm[0];
            end
            default: ok = 1'b0;
        endcase
        if (ok) begin
            r.err  = 1'b0;
            r.inst = (tmpl & ~mask) | placed;
        end else begin
            r.err  = 1'b1;
            r.inst = tmpl;
        end
        return r;
    endfunction

endpackage

// File: rtl/imm_enc_fifo.sv
// Small synchronous FIFO with registered full/empty flags. The head output
// holds the last popped word while the FIFO is empty.
module imm_enc_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [W-1:0]  last_q;
    logic          do_push;
    logic          do_pop;

    // Flags come from the registered state, so a pop never frees a slot for a same-cycle push.
    assign do_push = push & !full;
    assign do_pop  = pop & !empty;
    assign head    = empty ? last_q : mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push) count_next = count_next + CW'(1);
        if (do_pop)  count_next = count_next - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            last_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                last_q <= mem[rd_ptr];
            end
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/imm_encode.sv
// Packs a 32-bit immediate into an RV32 instruction template for the debug
// injection path, with a request register, output FIFO and error counter.
module imm_encode
    import imm_encode_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 8
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [31:0]      in_imm,
    input  logic [31:0]      in_tmpl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             clr_err
);

    logic        s1_valid;
    logic [2:0]  s1_op;
    logic [31:0] s1_imm;
    logic [31:0] s1_tmpl;
    enc_t        enc;
    logic        fifo_full;
    logic        fifo_empty;
    logic        accept;
    logic        push;
    logic        pop;

    assign in_ready  = !s1_valid | !fifo_full;
    assign accept    = in_valid & in_ready;
    assign push      = s1_valid & !fifo_full;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid & out_ready;
    assign enc       = encode_imm(s1_op, s1_imm, s1_tmpl);

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_imm   <= '0;
            s1_tmpl  <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_op    <= in_op;
                s1_imm   <= in_imm;
                s1_tmpl  <= in_tmpl;
            end else if (push) begin
                s1_valid <= 1'b0;
            end
        end
    end

    imm_enc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (33)
    ) u_fifo (
        .clk       (cpu_clk),
        .rst       (cpu_rst),
        .push      (push),
        .push_data ({enc.err, enc.inst}),
        .pop       (pop),
        .head      ({out_err, out_inst}),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // A clear takes priority over an increment landing on the same edge.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            err_cnt <= '0;
        end else if (clr_err) begin
            err_cnt <= '0;
        end else if (push && enc.err && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule
